// File: rtl/regarb_native.sv
// rtl/regarb_native.sv - round-robin arbiter of REQ_NUM register requesters onto one downstream port
//
// Purpose: each requester posts a one-cycle request into a one-entry pending
// buffer; a four-state FSM (IDLE/ISSUE/WAIT/RESP) grants pending buffers in
// round-robin order and runs one downstream transaction at a time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   requester__req_vld/addr/wr_en/rd_en/wr_data   per-requester request inputs
//   requester__ack_vld        per-requester one-cycle completion pulse
//   requester__rd_data        shared read data, valid only in the RESP cycle
//   downstream__*             single-outstanding downstream register port
//   timeout_err               one-cycle pulse with a timed-out completion
//
// Optional feature: define REGARB_NATIVE_TIMEOUT_EN to build the wait-state
// watchdog (TIMEOUT_CYCLES limit); otherwise WAIT waits indefinitely.

module regarb_native #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int REQ_NUM        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REQ_NUM-1:0]                   requester__req_vld,
    input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]   requester__addr,
    input  logic [REQ_NUM-1:0]                   requester__wr_en,
    input  logic [REQ_NUM-1:0]                   requester__rd_en,
    input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]   requester__wr_data,
    output logic [REQ_NUM-1:0]                   requester__ack_vld,
    output logic [DATA_WIDTH-1:0]                requester__rd_data,
    output logic                                 downstream__req_vld,
    output logic [ADDR_WIDTH-1:0]                downstream__addr,
    output logic                                 downstream__wr_en,
    output logic                                 downstream__rd_en,
    output logic [DATA_WIDTH-1:0]                downstream__wr_data,
    input  logic                                 downstream__ack_vld,
    input  logic [DATA_WIDTH-1:0]                downstream__rd_data,
    output logic                                 timeout_err
);

    localparam int GW = $clog2(REQ_NUM);
    localparam logic [GW:0] REQ_NUM_W = (GW+1)'(REQ_NUM);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [REQ_NUM-1:0]                 pend_q;
    logic [REQ_NUM-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [REQ_NUM-1:0]                 wr_en_q;
    logic [REQ_NUM-1:0]                 rd_en_q;
    logic [REQ_NUM-1:0][DATA_WIDTH-1:0] wr_data_q;

`ifdef REGARB_NATIVE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    logic          found;
    logic [GW:0]   cand;

    // Pending buffers: a pulse is only captured into an empty slot, and the
    // granted slot is released on the edge that ends its RESP cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (rst) begin
                pend_q[i]    <= 1'b0;
                addr_q[i]    <= '0;
                wr_en_q[i]   <= 1'b0;
                rd_en_q[i]   <= 1'b0;
                wr_data_q[i] <= '0;
            end else if (state_q == RESP && grant_q == GW'(i)) begin
                pend_q[i] <= 1'b0;
            end else if (requester__req_vld[i] && !pend_q[i]) begin
                pend_q[i]    <= 1'b1;
                addr_q[i]    <= requester__addr[i];
                wr_en_q[i]   <= requester__wr_en[i];
                rd_en_q[i]   <= requester__rd_en[i];
                wr_data_q[i] <= requester__wr_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(REQ_NUM - 1);
            data_q       <= '0;
`ifdef REGARB_NATIVE_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
`ifdef REGARB_NATIVE_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        data_d              = data_q;
        found               = 1'b0;
        cand                = '0;
        requester__ack_vld  = '0;
        requester__rd_data  = '0;
        downstream__req_vld = 1'b0;
        downstream__addr    = '0;
        downstream__wr_en   = 1'b0;
        downstream__rd_en   = 1'b0;
        downstream__wr_data = '0;
        timeout_err         = 1'b0;
`ifdef REGARB_NATIVE_TIMEOUT_EN
        cnt_d               = cnt_q;
        err_d               = err_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef REGARB_NATIVE_TIMEOUT_EN
                err_d = 1'b0;
`endif
                // Scan starting one past the last grant; k = REQ_NUM wraps
                // back to last_grant itself so a lone requester still wins.
                for (int k = 1; k <= REQ_NUM; k++) begin
                    cand = {1'b0, last_grant_q} + (GW+1)'(k);
                    if (cand >= REQ_NUM_W) cand = cand - REQ_NUM_W;
                    if (!found && pend_q[cand[GW-1:0]]) begin
                        found   = 1'b1;
                        grant_d = cand[GW-1:0];
                    end
                end
                if (found) begin
                    last_grant_d = grant_d;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                downstream__req_vld = 1'b1;
                downstream__addr    = addr_q[grant_q];
                downstream__wr_en   = wr_en_q[grant_q];
                downstream__rd_en   = rd_en_q[grant_q];
                downstream__wr_data = wr_data_q[grant_q];
                if (downstream__ack_vld) begin
                    data_d  = downstream__rd_data;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
`ifdef REGARB_NATIVE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (downstream__ack_vld) begin
                    // A real ack beats a coincident expiry.
                    data_d  = downstream__rd_data;
                    state_d = RESP;
                end
`ifdef REGARB_NATIVE_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = {DATA_WIDTH{1'b1}};
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                requester__ack_vld[grant_q] = 1'b1;
                requester__rd_data          = data_q;
`ifdef REGARB_NATIVE_TIMEOUT_EN
                timeout_err                 = err_q;
`endif
                state_d                     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regarb_native.sv
// tb/tb_regarb_native.sv - directed self-checking bench for regarb_native

module tb_regarb_native;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_vld, wr_en, rd_en;
    logic [1:0][63:0] addr;
    logic [1:0][31:0] wr_data;
    logic [1:0]       ack_vld;
    logic [31:0]      rd_data;
    logic             ds_req, ds_wr, ds_rd, ds_ack;
    logic [63:0]      ds_addr;
    logic [31:0]      ds_wdata, ds_rdata;
    logic             terr;

    int checks = 0;
    int errors = 0;

    regarb_native #(
        .ADDR_WIDTH(64), .DATA_WIDTH(32), .REQ_NUM(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .requester__req_vld(req_vld), .requester__addr(addr),
        .requester__wr_en(wr_en), .requester__rd_en(rd_en),
        .requester__wr_data(wr_data), .requester__ack_vld(ack_vld),
        .requester__rd_data(rd_data),
        .downstream__req_vld(ds_req), .downstream__addr(ds_addr),
        .downstream__wr_en(ds_wr), .downstream__rd_en(ds_rd),
        .downstream__wr_data(ds_wdata), .downstream__ack_vld(ds_ack),
        .downstream__rd_data(ds_rdata), .timeout_err(terr)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_vld = '0; wr_en = '0; rd_en = '0; addr = '0; wr_data = '0;
        ds_ack = 1'b0; ds_rdata = '0;
        cyc; cyc;
        checks++;
        if ({ds_req, ack_vld, terr, ds_wr, ds_rd} !== 6'b0 || rd_data !== 32'h0 || ds_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: ds_req=%0b ack=%b terr=%0b rd_data=%h ds_addr=%h want all 0",
                     ds_req, ack_vld, terr, rd_data, ds_addr);
        end
        rst = 1'b0;
        cyc;
    endtask

    task automatic test_single_read;
        addr[0] = 64'h1004; rd_en[0] = 1'b1; wr_en[0] = 1'b0; req_vld = 2'b01;
        cyc;                                             // T+1
        req_vld = '0;
        checks++;
        if (ds_req !== 1'b0) begin
            errors++; $display("FAIL rd_t1_no_issue: ds_req=%0b want 0", ds_req);
        end
        cyc;                                             // T+2 ISSUE
        checks++;
        if (ds_req !== 1'b1 || ds_addr !== 64'h1004 || ds_rd !== 1'b1 || ds_wr !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue: req=%0b addr=%h rd=%0b wr=%0b want 1 1004 1 0", ds_req, ds_addr, ds_rd, ds_wr);
        end
        cyc;                                             // T+3 first WAIT
        checks++;
        if (ds_req !== 1'b0 || ds_addr !== 64'h0) begin
            errors++; $display("FAIL rd_wait_quiet: req=%0b addr=%h want 0 0", ds_req, ds_addr);
        end
        addr[0] = 64'hDEAD; req_vld = 2'b01;             // must be ignored: slot busy
        cyc;                                             // T+4
        req_vld = '0;
        cyc;                                             // T+5 third WAIT
        ds_ack = 1'b1; ds_rdata = 32'hA5A5_0001;
        cyc;                                             // T+6 RESP
        checks++;
        if (ack_vld !== 2'b01 || rd_data !== 32'hA5A5_0001 || terr !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: ack=%b rd_data=%h terr=%0b want 01 a5a50001 0", ack_vld, rd_data, terr);
        end
        ds_ack = 1'b0; ds_rdata = '0;
        cyc;                                             // T+7 IDLE
        checks++;
        if (ack_vld !== 2'b00 || rd_data !== 32'h0) begin
            errors++; $display("FAIL rd_after_resp: ack=%b rd_data=%h want 00 0", ack_vld, rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            cyc;
            checks++;
            if (ds_req !== 1'b0) begin
                errors++; $display("FAIL busy_req_ignored: ds_req=%0b addr=%h want 0", ds_req, ds_addr);
            end
        end
    endtask

    task automatic test_zero_wait;
        addr[1] = 64'h20; wr_en[1] = 1'b1; rd_en[1] = 1'b0; wr_data[1] = 32'h55; req_vld = 2'b10;
        cyc;                                             // T+1
        req_vld = '0;
        cyc;                                             // T+2 ISSUE
        checks++;
        if (ds_req !== 1'b1 || ds_addr !== 64'h20 || ds_wr !== 1'b1 || ds_rd !== 1'b0 || ds_wdata !== 32'h55) begin
            errors++;
            $display("FAIL zw_issue: req=%0b addr=%h wr=%0b rd=%0b wdata=%h want 1 20 1 0 55",
                     ds_req, ds_addr, ds_wr, ds_rd, ds_wdata);
        end
        ds_ack = 1'b1; ds_rdata = 32'h1234;
        cyc;                                             // T+3 RESP directly
        ds_ack = 1'b0; ds_rdata = '0;
        checks++;
        if (ack_vld !== 2'b10 || rd_data !== 32'h1234) begin
            errors++; $display("FAIL zw_resp: ack=%b rd_data=%h want 10 1234", ack_vld, rd_data);
        end
        cyc;                                             // T+4 IDLE
        checks++;
        if (ack_vld !== 2'b00 || ds_req !== 1'b0) begin
            errors++; $display("FAIL zw_idle: ack=%b ds_req=%0b want 00 0", ack_vld, ds_req);
        end
        wr_en[1] = 1'b0;
    endtask

    task automatic test_contention;
        int         acks, exp_id, ncyc;
        logic [1:0] exp_ack;
        for (int rep = 0; rep < 4; rep++) begin
            addr[0] = 64'h100; addr[1] = 64'h101; rd_en = 2'b11; wr_en = 2'b00; req_vld = 2'b11;
            cyc;
            req_vld = '0;
            acks = 0; exp_id = 0; ncyc = 0;
            while (acks < 2 && ncyc < 20) begin
                if (ds_req === 1'b1) begin
                    checks++;
                    if (ds_addr !== 64'h100 + 64'(exp_id) || ack_vld !== 2'b00) begin
                        errors++;
                        $display("FAIL cont_issue: rep=%0d addr=%h ack=%b want %h 00",
                                 rep, ds_addr, ack_vld, 64'h100 + 64'(exp_id));
                    end
                    ds_ack = 1'b1; ds_rdata = 32'hC0 + 32'(exp_id);
                end else begin
                    ds_ack = 1'b0; ds_rdata = '0;
                end
                if (ack_vld !== 2'b00) begin
                    exp_ack = 2'b01 << exp_id;
                    checks++;
                    if (ack_vld !== exp_ack || rd_data !== 32'hC0 + 32'(exp_id)) begin
                        errors++;
                        $display("FAIL cont_ack: rep=%0d ack=%b rd=%h want %b %h",
                                 rep, ack_vld, rd_data, exp_ack, 32'hC0 + 32'(exp_id));
                    end
                    acks++; exp_id++;
                end
                cyc;
                ncyc++;
            end
            ds_ack = 1'b0; ds_rdata = '0;
            checks++;
            if (acks != 2) begin
                errors++; $display("FAIL cont_timeout: rep=%0d acks=%0d want 2", rep, acks);
            end
        end
        rd_en = 2'b00;
    endtask

    task automatic test_timeout;
        addr[0] = 64'h2000; rd_en[0] = 1'b1; req_vld = 2'b01;
        cyc;                                             // T+1
        req_vld = '0;
        cyc;                                             // T+2 ISSUE, no ack
        checks++;
        if (ds_req !== 1'b1) begin
            errors++; $display("FAIL to_issue: ds_req=%0b want 1", ds_req);
        end
`ifdef REGARB_NATIVE_TIMEOUT_EN
        for (int i = 3; i <= 10; i++) begin
            cyc;
            checks++;
            if (ack_vld !== 2'b00 || terr !== 1'b0) begin
                errors++; $display("FAIL to_wait: cyc=T+%0d ack=%b terr=%0b want 00 0", i, ack_vld, terr);
            end
        end
        cyc;                                             // T+11 RESP
        checks++;
        if (ack_vld !== 2'b01 || rd_data !== 32'hFFFF_FFFF || terr !== 1'b1) begin
            errors++;
            $display("FAIL to_resp: ack=%b rd=%h terr=%0b want 01 ffffffff 1", ack_vld, rd_data, terr);
        end
        ds_ack = 1'b1; ds_rdata = 32'h4321;              // stale ack
        cyc;
        checks++;
        if (ack_vld !== 2'b00 || terr !== 1'b0 || ds_req !== 1'b0) begin
            errors++; $display("FAIL to_stale1: ack=%b terr=%0b ds_req=%0b want 00 0 0", ack_vld, terr, ds_req);
        end
        cyc;
        ds_ack = 1'b0; ds_rdata = '0;
        checks++;
        if (ack_vld !== 2'b00 || rd_data !== 32'h0) begin
            errors++; $display("FAIL to_stale2: ack=%b rd=%h want 00 0", ack_vld, rd_data);
        end
`else
        for (int i = 3; i <= 14; i++) begin
            cyc;
            checks++;
            if (ack_vld !== 2'b00 || ds_req !== 1'b0 || terr !== 1'b0) begin
                errors++;
                $display("FAIL nto_wait: cyc=T+%0d ack=%b ds_req=%0b terr=%0b want 00 0 0", i, ack_vld, ds_req, terr);
            end
        end
        ds_ack = 1'b1; ds_rdata = 32'h77;
        cyc;
        ds_ack = 1'b0; ds_rdata = '0;
        checks++;
        if (ack_vld !== 2'b01 || rd_data !== 32'h77 || terr !== 1'b0) begin
            errors++; $display("FAIL nto_resp: ack=%b rd=%h terr=%0b want 01 77 0", ack_vld, rd_data, terr);
        end
        cyc;
`endif
        rd_en[0] = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        addr[0] = 64'h3000; rd_en[0] = 1'b1; req_vld = 2'b01;
        cyc;                                             // T+1
        req_vld = '0;
        cyc;                                             // T+2 ISSUE
        cyc;                                             // T+3 WAIT
        cyc;                                             // T+4 WAIT
        rst = 1'b1;
        cyc;                                             // T+5 after reset
        checks++;
        if ({ds_req, ack_vld, terr, ds_rd} !== 5'b0 || rd_data !== 32'h0 || ds_addr !== 64'h0) begin
            errors++;
            $display("FAIL rstw_outputs: ds_req=%0b ack=%b terr=%0b rd=%h addr=%h want all 0",
                     ds_req, ack_vld, terr, rd_data, ds_addr);
        end
        rst = 1'b0;
        ds_ack = 1'b1; ds_rdata = 32'h99;                // late ack for abandoned transaction
        cyc;
        ds_ack = 1'b0; ds_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ack_vld !== 2'b00 || ds_req !== 1'b0) begin
                errors++; $display("FAIL rstw_dropped: i=%0d ack=%b ds_req=%0b want 00 0", i, ack_vld, ds_req);
            end
            cyc;
        end
        rd_en[0] = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_zero_wait;
        test_contention;
        test_timeout;
        test_reset_mid_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
